// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone register-file initiator.
package wb_init_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } wb_init_state_e;

  localparam int WB_ADR_STRIDE     = 4;
  localparam int WB_WORD_SIZE_DEF  = 32;
  localparam int WB_ADR_W_DEF      = 32;
  localparam int WB_LEN_W_DEF      = 5;
  localparam int WB_TIMEOUT_DEF    = 255;
endpackage

// File: rtl/wb_init_watchdog.sv
// Ack watchdog: cleared on load, counts while enabled, flags the final waiting cycle.
module wb_init_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load,
  input  logic count,
  output logic expired
);
  logic [15:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + 16'd1;
  end

  // Asserted during the TIMEOUT_CYCLES-th cycle of waiting, so the bus drops right after it.
  assign expired = count && (cnt == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/wb_regfile_initiator.sv
// Wishbone classic initiator: one command -> N single-beat transfers -> N responses.
// Optional ack timeout enabled by defining WB_INIT_TIMEOUT_EN.
module wb_regfile_initiator
  import wb_init_pkg::*;
#(
  parameter int WORD_SIZE      = WB_WORD_SIZE_DEF,
  parameter int WHISBONE_ADR   = WB_ADR_W_DEF,
  parameter int LEN_W          = WB_LEN_W_DEF,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [WHISBONE_ADR-1:0] req_adr_i,
  input  logic [WORD_SIZE-1:0]    req_dat_i,
  input  logic [3:0]              req_sel_i,
  input  logic [LEN_W-1:0]        req_len_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WORD_SIZE-1:0]    rsp_dat_o,
  output logic                    rsp_err_o,
  output logic                    rsp_last_o,
  output logic                    busy_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [3:0]              wbm_sel_o,
  output logic [WHISBONE_ADR-1:0] wbm_adr_o,
  output logic [WORD_SIZE-1:0]    wbm_dat_o,
  input  logic [WORD_SIZE-1:0]    wbm_dat_i,
  input  logic                    wbm_ack_i
);
  wb_init_state_e   state;
  logic [LEN_W-1:0] beats_left;
  logic             expired;

`ifdef WB_INIT_TIMEOUT_EN
  logic issue_entry;
  assign issue_entry = (state == IDLE && req_valid_i) ||
                       (state == RESP && rsp_ready_i && !rsp_last_o);

  wb_init_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (issue_entry),
    .count   (state == ISSUE),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      beats_left  <= '0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      rsp_last_o  <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          wbm_we_o    <= req_we_i;
          wbm_adr_o   <= req_adr_i;
          wbm_dat_o   <= req_dat_i;
          wbm_sel_o   <= req_sel_i;
          beats_left  <= (req_len_i == '0) ? LEN_W'(1) : req_len_i;
          wbm_cyc_o   <= 1'b1;
          wbm_stb_o   <= 1'b1;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_last_o  <= (beats_left == LEN_W'(1));
            state       <= RESP;
          end else if (expired) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_last_o  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          if (rsp_last_o) begin
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end else begin
            beats_left  <= beats_left - LEN_W'(1);
            wbm_adr_o   <= wbm_adr_o + WHISBONE_ADR'(WB_ADR_STRIDE);
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            state       <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_regfile_initiator.sv
// Directed bench for wb_regfile_initiator with a small Wishbone responder model.
// Timeout expectations follow WB_INIT_TIMEOUT_EN.
module tb_wb_regfile_initiator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic [4:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile_initiator #(.WORD_SIZE(32), .WHISBONE_ADR(32), .LEN_W(5), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_last_o(rsp_last), .busy_o(busy),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_ack_i(ack)
  );

  // Responder: 16-word memory, programmable wait states, optional never-ack.
  logic [31:0] mem [16];
  int          wait_st = 0;
  int          wcnt = 0;
  logic        noack = 1'b0;
  logic [31:0] bus_adr_q [$];
  logic        bus_we_q  [$];
  int          rsp_seen = 0;

  assign ack  = cyc && stb && !noack && (wcnt >= wait_st);
  assign rdat = mem[adr[5:2]];

  always @(posedge clk) begin
    if (!cyc) wcnt <= 0;
    else if (!ack) wcnt <= wcnt + 1;
    if (ack) begin
      bus_adr_q.push_back(adr);
      bus_we_q.push_back(we);
      if (we)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem[adr[5:2]][b*8 +: 8] <= wdat[b*8 +: 8];
    end
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [4:0]  len;
    int          n;
    int          wait_st;
    int          stall;
    logic [3:0][31:0] exp_dat;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [4:0] l, input int n,
                              input int ws, input int st, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s; v.len = l; v.n = n;
    v.wait_st = ws; v.stall = st;
    v.exp_dat[0] = d0; v.exp_dat[1] = d1; v.exp_dat[2] = d2; v.exp_dat[3] = d3;
    return v;
  endfunction

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [4:0] l);
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_we = w; req_adr = a; req_dat = d; req_sel = s; req_len = l;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int got = 0;
    int sc = 0;
    bit done = 0;
    bus_adr_q.delete();
    bus_we_q.delete();
    wait_st = v.wait_st;
    drive_req(v.we, v.adr, v.dat, v.sel, v.len);
    for (int t = 0; t < 300 && !done; t++) begin
      if (rsp_valid) begin
        if (sc < v.stall) begin
          rsp_ready = 1'b0;
          sc++;
          chk($sformatf("v%0d_cyc_stalled", idx), {31'd0, cyc}, 32'd0);
        end else begin
          if (got < 4) chk($sformatf("v%0d_dat%0d", idx, got), rsp_dat, v.exp_dat[got]);
          chk($sformatf("v%0d_err%0d", idx, got), {31'd0, rsp_err}, 32'd0);
          chk($sformatf("v%0d_last%0d", idx, got), {31'd0, rsp_last}, {31'd0, got == v.n - 1});
          rsp_ready = 1'b1;
          sc = 0;
          got++;
          if (rsp_last) done = 1;
        end
      end else rsp_ready = 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_ready_back", idx), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d_nrsp", idx), got, v.n);
    chk($sformatf("v%0d_nbus", idx), bus_adr_q.size(), v.n);
    for (int i = 0; i < v.n && i < bus_adr_q.size(); i++) begin
      chk($sformatf("v%0d_adr%0d", idx, i), bus_adr_q[i], v.adr + 32'(4 * i));
      chk($sformatf("v%0d_we%0d", idx, i), {31'd0, bus_we_q[i]}, {31'd0, v.we});
    end
  endtask

  vec_t vecs [6];

  initial begin
    int cnt;
    int snap;
    logic [5:0] exp_cyc, exp_vld;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0; req_len = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;

    vecs[0] = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 5'd1, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1] = mk(1'b0, 32'h10, 32'h0, 4'hF, 5'd0, 1, 2, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(1'b0, 32'h0, 32'h0, 4'hF, 5'd4, 4, 0, 3,
                 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);
    vecs[3] = mk(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 5'd2, 2, 0, 0,
                 32'h1000_000F, 32'h1000_0000, 32'h0, 32'h0);
    vecs[4] = mk(1'b1, 32'h4, 32'h1122_3344, 4'h3, 5'd2, 2, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[5] = mk(1'b0, 32'h4, 32'h0, 4'hF, 5'd2, 2, 1, 1, 32'h1000_3344, 32'h1000_3344, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], i);

    // Zero-wait, rsp_ready held high: two cycles per beat, ready back after last handshake
    wait_st = 0;
    @(negedge clk);
    req_we = 1'b0; req_adr = 32'h20; req_sel = 4'hF; req_len = 5'd3;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_cyc = 6'b010101;
    exp_vld = 6'b101010;
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("pipe_cyc%0d", s), {31'd0, cyc}, {31'd0, exp_cyc[s]});
      chk($sformatf("pipe_vld%0d", s), {31'd0, rsp_valid}, {31'd0, exp_vld[s]});
      chk($sformatf("pipe_rdy%0d", s), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("pipe_ready_back", {31'd0, req_ready}, 32'd1);
    chk("pipe_busy_low", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b0;

    // Responder never acks
    noack = 1'b1;
    drive_req(1'b0, 32'h40, 32'h0, 4'hF, 5'd3);
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (rsp_valid) break;
      if (cyc) cnt++;
      @(negedge clk);
    end
`ifdef WB_INIT_TIMEOUT_EN
    chk("to_cyc_cycles", cnt, 8);
    chk("to_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_err", {31'd0, rsp_err}, 32'd1);
    chk("to_dat", rsp_dat, 32'd0);
    chk("to_last", {31'd0, rsp_last}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_ready_back", {31'd0, req_ready}, 32'd1);
    chk("to_cyc_low", {31'd0, cyc}, 32'd0);
`else
    chk("nto_cyc_cycles", cnt, 40);
    chk("nto_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("nto_err", {31'd0, rsp_err}, 32'd0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    noack = 1'b0;

    // Reset during ISSUE of beat 2
    bus_adr_q.delete();
    bus_we_q.delete();
    drive_req(1'b0, 32'h0, 32'h0, 4'hF, 5'd3);
    for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    chk("mid_first_rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    noack = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("mid_beat2_cyc", {31'd0, cyc}, 32'd1);
    chk("mid_beat2_adr", adr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    snap = rsp_seen;
    chk("mid_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_adr", adr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    noack = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_no_rsp", rsp_seen, snap);
    chk("mid_idle_cyc", {31'd0, cyc}, 32'd0);
    run_cmd(vecs[1], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
